// File: rtl/fifo_bit_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bit_deserializer
// Description : Pops a 1-bit FIFO, hunts for a sync word, then assembles
//               MSB-first words onto a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_bit_deserializer #(
    parameter int                    WORD_WIDTH = 8,
    parameter logic [WORD_WIDTH-1:0] SYNC_WORD  = 8'hBC,
    parameter bit                    DROP_SYNC  = 1'b1
) (
    input  logic                  i_Rclk,
    input  logic                  i_Rrst_n,
    input  logic                  i_empty,
    input  logic                  i_Data_In,
    output logic                  o_R_en,
    input  logic                  i_resync,
    output logic [WORD_WIDTH-1:0] o_Word,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic                  o_Locked
);

    localparam int                 c_CNT_W     = $clog2(WORD_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_HUNT_MAX  = c_CNT_W'(WORD_WIDTH);
    localparam logic [c_CNT_W-1:0] c_HUNT_MIN  = c_CNT_W'(WORD_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(WORD_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state,    w_state_nxt;
    // Only the older WORD_WIDTH-1 bits need storing; the newest is i_Data_In.
    logic [WORD_WIDTH-2:0]   r_sr,       w_sr_nxt;
    logic [c_CNT_W-1:0]      r_bit_cnt,  w_bit_cnt_nxt;
    logic [c_CNT_W-1:0]      r_hunt_cnt, w_hunt_cnt_nxt;
    logic [WORD_WIDTH-1:0]   r_word,     w_word_nxt;
    logic                    r_valid,    w_valid_nxt;

    logic                    w_pop;
    logic                    w_load;
    logic [WORD_WIDTH-1:0]   w_sr_next;
    logic                    w_is_sync;

    assign w_pop     = i_Rrst_n & ~i_empty & ~i_resync & (~r_valid | i_Ready);
    assign w_sr_next = {r_sr, i_Data_In};
    assign w_is_sync = (w_sr_next == SYNC_WORD);

    assign o_R_en   = w_pop;
    assign o_Word   = r_word;
    assign o_Valid  = r_valid;
    assign o_Locked = (r_state == ST_LOCKED);

    always_comb begin
        w_state_nxt    = r_state;
        w_sr_nxt       = r_sr;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_hunt_cnt_nxt = r_hunt_cnt;
        w_word_nxt     = r_word;
        w_valid_nxt    = r_valid;
        w_load         = 1'b0;

        if (i_resync) begin
            w_state_nxt    = ST_HUNT;
            w_sr_nxt       = '0;
            w_bit_cnt_nxt  = '0;
            w_hunt_cnt_nxt = '0;
            w_valid_nxt    = 1'b0;
        end else begin
            if (w_pop) begin
                w_sr_nxt = w_sr_next[WORD_WIDTH-2:0];
                case (r_state)
                    ST_HUNT: begin
                        if (r_hunt_cnt < c_HUNT_MAX) begin
                            w_hunt_cnt_nxt = r_hunt_cnt + 1'b1;
                        end
                        // Guard keeps reset-zero bits out of the comparison.
                        if ((r_hunt_cnt >= c_HUNT_MIN) && w_is_sync) begin
                            w_state_nxt   = ST_LOCKED;
                            w_bit_cnt_nxt = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_bit_cnt_nxt = '0;
                            if (!((DROP_SYNC == 1'b1) && w_is_sync)) begin
                                w_load = 1'b1;
                            end
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                    default: w_state_nxt = ST_HUNT;
                endcase
            end

            // A word completing on an accept edge replaces the old one.
            if (w_load) begin
                w_word_nxt  = w_sr_next;
                w_valid_nxt = 1'b1;
            end else if (r_valid && i_Ready) begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
        if (!i_Rrst_n) begin
            r_state    <= ST_HUNT;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_hunt_cnt <= '0;
            r_word     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_hunt_cnt <= w_hunt_cnt_nxt;
            r_word     <= w_word_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_bit_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_bit_deserializer
// Description : Self-checking bench: directed word table, corner sequences and
//               randomized traffic against a bit-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_bit_deserializer;

    localparam int         c_W    = 8;
    localparam logic [7:0] c_SYNC = 8'hBC;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_empty, i_Data_In, i_resync, i_Ready;
    logic           o_R_en, o_Valid, o_Locked;
    logic [c_W-1:0] o_Word;
    logic           o_R_en1, o_Valid1, o_Locked1;
    logic [c_W-1:0] o_Word1;

    always #5 clk = ~clk;

    fifo_bit_deserializer #(.WORD_WIDTH(c_W), .SYNC_WORD(c_SYNC), .DROP_SYNC(1'b1)) u_dut (
        .i_Rclk(clk), .i_Rrst_n(rst_n), .i_empty(i_empty), .i_Data_In(i_Data_In),
        .o_R_en(o_R_en), .i_resync(i_resync), .o_Word(o_Word), .o_Valid(o_Valid),
        .i_Ready(i_Ready), .o_Locked(o_Locked)
    );

    fifo_bit_deserializer #(.WORD_WIDTH(c_W), .SYNC_WORD(c_SYNC), .DROP_SYNC(1'b0)) u_dut_keep (
        .i_Rclk(clk), .i_Rrst_n(rst_n), .i_empty(i_empty), .i_Data_In(i_Data_In),
        .o_R_en(o_R_en1), .i_resync(i_resync), .o_Word(o_Word1), .o_Valid(o_Valid1),
        .i_Ready(i_Ready), .o_Locked(o_Locked1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the last WORD_WIDTH popped bits plus lock/word state
    bit             hist[$];
    bit             m_locked;
    int             m_bits;
    bit             m_valid;
    logic [c_W-1:0] m_word;

    function automatic logic [c_W-1:0] hist_val();
        logic [c_W-1:0] v = '0;
        foreach (hist[i]) v = {v[c_W-2:0], hist[i]};
        return v;
    endfunction

    task automatic model_clear(input bit clr_word);
        hist.delete();
        m_locked = 1'b0;
        m_bits   = 0;
        m_valid  = 1'b0;
        if (clr_word) m_word = '0;
    endtask

    task automatic model_step(input bit pop, input bit din, input bit rsy, input bit rdy);
        bit new_word = 1'b0;
        if (rsy) begin
            model_clear(1'b0);
            return;
        end
        if (pop) begin
            hist.push_back(din);
            if (hist.size() > c_W) void'(hist.pop_front());
            if (!m_locked) begin
                if (hist.size() == c_W && hist_val() == c_SYNC) begin
                    m_locked = 1'b1;
                    m_bits   = 0;
                end
            end else begin
                m_bits++;
                if (m_bits == c_W) begin
                    m_bits = 0;
                    if (hist_val() != c_SYNC) new_word = 1'b1;
                end
            end
        end
        if (new_word) begin
            m_valid = 1'b1;
            m_word  = hist_val();
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Bit source and observation state
    bit             src[$];
    logic [c_W-1:0] got[$];
    logic [c_W-1:0] got1[$];
    int             pop_total = 0;
    int             lock_at, valid_at;
    bit             prev_lock, prev_valid;

    task automatic push_word(input logic [c_W-1:0] w);
        for (int i = c_W - 1; i >= 0; i--) src.push_back(w[i]);
    endtask

    task automatic clear_obs();
        got.delete();
        got1.delete();
        lock_at   = -1;
        valid_at  = -1;
        prev_lock = o_Locked;
        prev_valid = o_Valid;
    endtask

    task automatic tick(input bit gap, input bit rdy, input bit rsy);
        bit exp_pop, ren_seen, din;
        i_empty   = gap | (src.size() == 0);
        i_Ready   = rdy;
        i_resync  = rsy;
        i_Data_In = (src.size() != 0) ? src[0] : 1'b0;
        @(negedge clk);
        if (!rst_n) model_clear(1'b1);
        chk("valid", o_Valid, m_valid);
        chk("locked", o_Locked, m_locked);
        chk("word", o_Word, m_word);
        exp_pop = rst_n & ~i_empty & ~rsy & (~m_valid | rdy);
        chk("r_en", o_R_en, exp_pop);
        if (o_Locked && !prev_lock && lock_at < 0) lock_at = pop_total;
        if (o_Valid && !prev_valid && valid_at < 0) valid_at = pop_total;
        prev_lock  = o_Locked;
        prev_valid = o_Valid;
        if (o_Valid && rdy) got.push_back(o_Word);
        if (o_Valid1 && rdy) got1.push_back(o_Word1);
        ren_seen = o_R_en;
        din      = i_Data_In;
        @(posedge clk);
        if (rst_n) model_step(exp_pop, din, rsy, rdy);
        if (ren_seen && src.size() != 0) begin
            void'(src.pop_front());
            pop_total++;
        end
        #1;
    endtask

    task automatic run_out(input string name);
        for (int i = 0; i < 300 && src.size() != 0; i++) tick(1'b0, 1'b1, 1'b0);
        chk({name, "_drain_timeout"}, src.size(), 0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", o_Valid, 1'b0);
        chk("arst_locked", o_Locked, 1'b0);
        chk("arst_word", o_Word, 0);
        chk("arst_r_en", o_R_en, 1'b0);
        model_clear(1'b1);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [c_W-1:0] data;
        int             gap_at;
        int             gap_len;
        bit             exp_out;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int p0, gapped;
        rst_n = 1'b0; i_empty = 1'b0; i_Data_In = 1'b0; i_resync = 1'b0; i_Ready = 1'b1;
        model_clear(1'b1);

        // Reset with data available, then alignment 1,0,1,BC,5A
        src.push_back(1'b1); src.push_back(1'b0); src.push_back(1'b1);
        push_word(c_SYNC);
        push_word(8'h5A);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            chk("rst_r_en", o_R_en, 1'b0);
            chk("rst_word", o_Word, 0);
        end
        rst_n = 1'b1;
        clear_obs();
        run_out("align");
        chk("align_lock_at", lock_at, 11);
        chk("align_valid_at", valid_at, 19);
        chk("align_count", got.size(), 1);
        chk("align_word", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 8'h5A);

        // Locked word table: gaps and sync stripping
        vecs[0] = '{8'hA5, 3, 5, 1'b1};
        vecs[1] = '{8'h11, -1, 0, 1'b1};
        vecs[2] = '{c_SYNC, -1, 0, 1'b0};
        vecs[3] = '{8'h22, -1, 0, 1'b1};
        vecs[4] = '{8'h00, 0, 2, 1'b1};
        vecs[5] = '{8'hFF, 7, 3, 1'b1};
        foreach (vecs[v]) begin
            clear_obs();
            p0 = pop_total;
            gapped = 0;
            push_word(vecs[v].data);
            for (int i = 0; i < 100 && src.size() != 0; i++) begin
                if ((pop_total - p0) == vecs[v].gap_at && gapped < vecs[v].gap_len) begin
                    tick(1'b1, 1'b1, 1'b0);
                    gapped++;
                end else begin
                    tick(1'b0, 1'b1, 1'b0);
                end
            end
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b1, 1'b0);
            chk("vec_pops", pop_total - p0, 8);
            chk("vec_count", got.size(), vecs[v].exp_out);
            if (vecs[v].exp_out)
                chk("vec_word", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, vecs[v].data);
        end

        // Backpressure: stall on 0x3C while 0xC3 is queued behind it
        clear_obs();
        push_word(8'h3C);
        push_word(8'hC3);
        for (int i = 0; i < 50 && src.size() > 8; i++) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("bp_word", o_Word, 8'h3C);
            chk("bp_valid", o_Valid, 1'b1);
        end
        chk("bp_src_held", src.size(), 8);
        run_out("bp");
        chk("bp_count", got.size(), 2);
        chk("bp_first", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 8'h3C);
        chk("bp_second", (got.size() > 1) ? 32'(got[1]) : 32'hDEAD, 8'hC3);

        // Resync then async reset in the middle of 0x77
        for (int r = 0; r < 2; r++) begin
            clear_obs();
            push_word(8'h77);
            for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0);
            if (r == 0) begin
                tick(1'b0, 1'b1, 1'b1);
                chk("resync_locked", o_Locked, 1'b0);
                chk("resync_valid", o_Valid, 1'b0);
                chk("resync_no_pop", src.size(), 4);
            end else begin
                async_reset();
            end
            src.delete();
            clear_obs();
            push_word(c_SYNC);
            push_word(8'h42);
            run_out("relock");
            chk("relock_locked", o_Locked, 1'b1);
            chk("relock_count", got.size(), 1);
            chk("relock_word", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 8'h42);
        end

        // Randomized traffic with periodic sync words and rare resyncs
        for (int i = 0; i < 3000; i++) begin
            if (src.size() < 16) begin
                push_word(c_SYNC);
                for (int k = 0; k < 4; k++)
                    push_word(($urandom_range(0, 9) == 0) ? c_SYNC : c_W'($urandom));
            end
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
        end

        // DROP_SYNC=0 instance outputs the in-lock sync word
        src.delete();
        async_reset();
        clear_obs();
        push_word(c_SYNC);
        push_word(8'h11);
        push_word(c_SYNC);
        push_word(8'h22);
        run_out("keep");
        chk("keep_count", got1.size(), 3);
        chk("keep_w0", (got1.size() > 0) ? 32'(got1[0]) : 32'hDEAD, 8'h11);
        chk("keep_w1", (got1.size() > 1) ? 32'(got1[1]) : 32'hDEAD, c_SYNC);
        chk("keep_w2", (got1.size() > 2) ? 32'(got1[2]) : 32'hDEAD, 8'h22);
        chk("drop_count", got.size(), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
